// File: rtl/sram_port_arbiter_if.sv
// Signal bundle between the fetch/data requesters, the port arbiter and the memory bus.
// master = arbiter side, slave = requesters plus downstream memory.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_cancel;
    logic              inst_done;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic              data_wr;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_done;
    logic [DATA_W-1:0] data_rdata;

    logic              mem_req;
    logic              mem_wr;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport master (
        input  inst_req, inst_addr, inst_cancel,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output inst_done, inst_rdata, data_done, data_rdata,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        output busy
    );

    modport slave (
        output inst_req, inst_addr, inst_cancel,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  inst_done, inst_rdata, data_done, data_rdata,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between fetch and load/store; data has priority,
// fetch is guaranteed a slot after MAX_DATA_RUN back-to-back data grants.
module sram_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_DATA_RUN = 4
) (
    input logic               clk,
    input logic               resetn,
    sram_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    typedef struct packed {
        logic              wr;
        logic [3:0]        wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

    state_t            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic              mem_req_q, mem_req_d;
    logic              owner_q, owner_d;      // 1 = fetch owns the port
    logic [3:0]        run_cnt_q, run_cnt_d;
    logic              cancel_q, cancel_d;
    logic              inst_done_q, inst_done_d;
    logic              data_done_q, data_done_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic              busy_q, busy_d;

    logic inst_vld, inst_turn, pick_data, pick_inst;
    logic grant_data, grant_inst, complete;

    // Priority is decided on the raw requests; a requester whose done pulse is
    // visible this cycle is still showing its finished request, so if it wins
    // the slot stays empty for one cycle rather than handing it to the other side.
    always_comb begin
        inst_vld   = bus.inst_req && !bus.inst_cancel;
        inst_turn  = inst_vld && (run_cnt_q == RUN_MAX);
        pick_data  = bus.data_req && !inst_turn;
        pick_inst  = !pick_data && inst_vld;
        grant_data = pick_data && !data_done_q;
        grant_inst = pick_inst && !inst_done_q;
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        mem_req_d    = mem_req_q;
        owner_d      = owner_q;
        run_cnt_d    = run_cnt_q;
        cancel_d     = cancel_q;
        inst_done_d  = 1'b0;
        data_done_d  = 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        complete     = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    owner_d   = 1'b0;
                    cmd_d     = '{wr: bus.data_wr, wstrb: bus.data_wstrb,
                                  addr: bus.data_addr, wdata: bus.data_wdata};
                    mem_req_d = 1'b1;
                    cancel_d  = 1'b0;
                    state_d   = REQ;
                end else if (grant_inst) begin
                    owner_d   = 1'b1;
                    cmd_d     = '{wr: 1'b0, wstrb: 4'b0000,
                                  addr: bus.inst_addr, wdata: '0};
                    mem_req_d = 1'b1;
                    cancel_d  = 1'b0;
                    state_d   = REQ;
                end
                if (grant_inst || !bus.inst_req)
                    run_cnt_d = '0;
                else if (grant_data && run_cnt_q != RUN_MAX)
                    run_cnt_d = run_cnt_q + 4'd1;
            end
            REQ: begin
                if (bus.mem_addr_ok) begin
                    mem_req_d = 1'b0;
                    if (bus.mem_data_ok) complete = 1'b1;
                    else                 state_d  = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_data_ok) complete = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // A flushed fetch still has to finish on the bus; only its result is dropped.
        if (state_q != IDLE && owner_q && bus.inst_cancel)
            cancel_d = 1'b1;

        if (complete) begin
            state_d  = IDLE;
            cancel_d = 1'b0;
            if (owner_q) begin
                if (!(cancel_q || bus.inst_cancel)) begin
                    inst_done_d  = 1'b1;
                    inst_rdata_d = bus.mem_rdata;
                end
            end else begin
                data_done_d  = 1'b1;
                data_rdata_d = bus.mem_rdata;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            mem_req_q    <= 1'b0;
            owner_q      <= 1'b0;
            run_cnt_q    <= '0;
            cancel_q     <= 1'b0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            mem_req_q    <= mem_req_d;
            owner_q      <= owner_d;
            run_cnt_q    <= run_cnt_d;
            cancel_q     <= cancel_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_wr     = cmd_q.wr;
    assign bus.mem_wstrb  = cmd_q.wstrb;
    assign bus.mem_addr   = cmd_q.addr;
    assign bus.mem_wdata  = cmd_q.wdata;
    assign bus.inst_done  = inst_done_q;
    assign bus.inst_rdata = inst_rdata_q;
    assign bus.data_done  = data_done_q;
    assign bus.data_rdata = data_rdata_q;
    assign bus.busy       = busy_q;
endmodule
